// File: rtl/conv_pkg.sv
// Shared definitions for the streaming 2-D convolution block.
//   conv_state_t : frame controller states
//   CONV_ACC_W   : natural full-precision result width for the default
//                  DATA_W/K (2*DATA_W + clog2(K*K))
//   conv_sum_w() : the same derivation for arbitrary DATA_W/K
//   conv_sat()   : clamp a wide signed value into a signed w-bit range
package conv_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} conv_state_t;

  localparam int CONV_DATA_W = 8;
  localparam int CONV_K      = 3;
  localparam int CONV_ACC_W  = 2 * CONV_DATA_W + $clog2(CONV_K * CONV_K);

  // Width of the saturation datapath; any SUM_W/ACC_W up to this works.
  localparam int SAT_W = 64;

  function automatic int conv_sum_w(input int data_w, input int k);
    return 2 * data_w + $clog2(k * k);
  endfunction

  function automatic logic signed [SAT_W-1:0] conv_sat(
    input logic signed [SAT_W-1:0] v,
    input int unsigned             w
  );
    logic signed [SAT_W-1:0] hi;
    logic signed [SAT_W-1:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    if (v > hi)      return hi;
    else if (v < lo) return lo;
    else             return v;
  endfunction

endpackage

// File: rtl/conv_line_buf.sv
// One image-row delay line for the convolution window.
// dout is the pixel written DEPTH accepted pixels ago; the buffer only
// advances when en is high, so a stalled pipeline leaves it untouched.
//   clk, reset (async, active low), en (pixel accepted),
//   din (pixel entering), dout (pixel one row earlier)
module conv_line_buf
  import conv_pkg::*;
#(
  parameter int DEPTH  = 6,
  parameter int DATA_W = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     en,
  input  logic signed [DATA_W-1:0] din,
  output logic signed [DATA_W-1:0] dout
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic signed [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]         ptr;

  // Read-before-write at the same slot gives exactly DEPTH cycles of delay.
  assign dout = mem[ptr];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (en) begin
      mem[ptr] <= din;
      ptr      <= (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + 1'b1;
    end
  end

endmodule

// File: rtl/conv_stream.sv
// Streaming KxK valid-window convolution over an IMG_W x IMG_H raster frame.
// Coefficients are loaded row-major in IDLE; CONV_start opens a frame.
// Pipeline: stage 1 registers the KxK products, stage 2 sums, saturates
// to ACC_W and registers the output (result two cycles after the window's
// bottom-right pixel is accepted). A held output (oValid && !oReady)
// freezes the whole pipeline and drops CONV_iReady.
// Optional build macro: CONV_RELU_EN clamps negative results to 0.
//   clk, reset (async, active low)
//   CONV_start            : frame-open pulse (IDLE only)
//   CONV_wData/CONV_wValid: coefficient load (IDLE only)
//   CONV_iData/iValid/iReady: pixel stream in
//   CONV_oData/oValid/oReady: result stream out
//   CONV_finish           : one-cycle pulse after the last result is taken
module conv_stream
  import conv_pkg::*;
#(
  parameter int IMG_W  = 6,
  parameter int IMG_H  = 6,
  parameter int K      = 3,
  parameter int DATA_W = 8,
  parameter int ACC_W  = CONV_ACC_W
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     CONV_start,
  input  logic signed [DATA_W-1:0] CONV_wData,
  input  logic                     CONV_wValid,
  input  logic signed [DATA_W-1:0] CONV_iData,
  input  logic                     CONV_iValid,
  output logic                     CONV_iReady,
  output logic signed [ACC_W-1:0]  CONV_oData,
  output logic                     CONV_oValid,
  input  logic                     CONV_oReady,
  output logic                     CONV_finish
);

  localparam int NC    = K * K;
  localparam int PW    = 2 * DATA_W;
  localparam int SUM_W = conv_sum_w(DATA_W, K);
  localparam int COL_W = $clog2(IMG_W + 1);
  localparam int ROW_W = $clog2(IMG_H + 1);
  localparam int IDX_W = $clog2(NC + 1);

  conv_state_t state, state_nxt;

  logic                     stall, accept, last_pix, pipe_empty;
  logic [COL_W-1:0]         col;
  logic [ROW_W-1:0]         row;
  logic [IDX_W-1:0]         widx;
  logic signed [DATA_W-1:0] coef    [NC];
  logic signed [DATA_W-1:0] tap     [K];
  logic signed [DATA_W-1:0] win     [K][K];
  logic signed [DATA_W-1:0] win_nxt [K][K];
  logic signed [PW-1:0]     prod    [NC];
  logic                     p_valid;
  logic signed [SUM_W-1:0]  sum;
  logic signed [ACC_W-1:0]  res;

  assign stall      = CONV_oValid && !CONV_oReady;
  assign accept     = CONV_iValid && CONV_iReady;
  assign last_pix   = (row == ROW_W'(IMG_H - 1)) && (col == COL_W'(IMG_W - 1));
  assign pipe_empty = !p_valid && (!CONV_oValid || CONV_oReady);

  // ---------------- frame controller ----------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (CONV_start) state_nxt = RUN;
      RUN:     if (accept && last_pix) state_nxt = DRAIN;
      DRAIN:   if (pipe_empty) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    CONV_iReady = (state == RUN) && !stall;
    CONV_finish = (state == DONE);
  end

  // ---------------- coefficient store ----------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      widx <= '0;
      for (int unsigned i = 0; i < NC; i++) coef[i] <= '0;
    end else if (state == IDLE) begin
      if (CONV_start) begin
        widx <= '0;
      end else if (CONV_wValid) begin
        coef[widx] <= CONV_wData;
        widx       <= (widx == IDX_W'(NC - 1)) ? '0 : widx + 1'b1;
      end
    end
  end

  // ---------------- raster position ----------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      col <= '0;
      row <= '0;
    end else if (state == IDLE && CONV_start) begin
      col <= '0;
      row <= '0;
    end else if (accept) begin
      if (col == COL_W'(IMG_W - 1)) begin
        col <= '0;
        row <= row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end

  // ---------------- row delays and window ----------------
  // tap[i] is the pixel i rows above the incoming one, same column.
  assign tap[0] = CONV_iData;

  for (genvar g = 0; g < K - 1; g++) begin : g_lb
    conv_line_buf #(
      .DEPTH  (IMG_W),
      .DATA_W (DATA_W)
    ) u_lb (
      .clk   (clk),
      .reset (reset),
      .en    (accept),
      .din   (tap[g]),
      .dout  (tap[g+1])
    );
  end

  // Window row 0 is the oldest image row, column K-1 the newest pixel.
  always_comb begin
    for (int unsigned r = 0; r < K; r++) begin
      for (int unsigned c = 0; c + 1 < K; c++) win_nxt[r][c] = win[r][c+1];
      win_nxt[r][K-1] = tap[K-1-r];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned r = 0; r < K; r++)
        for (int unsigned c = 0; c < K; c++) win[r][c] <= '0;
    end else if (accept) begin
      win <= win_nxt;
    end
  end

  // ---------------- arithmetic pipeline ----------------
  // Products are taken from the shifted-in window so the multiply stage
  // lines up with the pixel-accept edge, keeping total latency at two.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      p_valid     <= 1'b0;
      CONV_oValid <= 1'b0;
      CONV_oData  <= '0;
      for (int unsigned i = 0; i < NC; i++) prod[i] <= '0;
    end else if (!stall) begin
      p_valid <= accept && (row >= ROW_W'(K - 1)) && (col >= COL_W'(K - 1));
      if (accept) begin
        for (int unsigned r = 0; r < K; r++)
          for (int unsigned c = 0; c < K; c++)
            prod[r*K+c] <= PW'(win_nxt[r][c]) * PW'(coef[r*K+c]);
      end
      CONV_oValid <= p_valid;
      if (p_valid) CONV_oData <= res;
    end
  end

  always_comb begin
    sum = '0;
    for (int unsigned i = 0; i < NC; i++) sum = sum + SUM_W'(prod[i]);
    res = ACC_W'(conv_sat(SAT_W'(sum), ACC_W));
`ifdef CONV_RELU_EN
    if (res < 0) res = '0;
`endif
  end

endmodule

// File: tb/tb_conv_stream.sv
module tb_conv_stream;

  localparam int W     = 6;
  localparam int H     = 6;
  localparam int K     = 3;
  localparam int DW    = 8;
  localparam int NPIX  = W * H;
  localparam int NC    = K * K;
  localparam int NOUT  = (H - K + 1) * (W - K + 1);
  localparam int ACC_A = 20;
  localparam int ACC_B = 16;

  logic clk = 1'b0;
  logic reset;
  logic start, wValid, iValid, oReady;
  logic signed [DW-1:0] wData, iData;
  logic iReady_a, oValid_a, finish_a;
  logic iReady_b, oValid_b, finish_b;
  logic signed [ACC_A-1:0] oData_a;
  logic signed [ACC_B-1:0] oData_b;

  always #5 clk = ~clk;

  conv_stream #(.IMG_W(W), .IMG_H(H), .K(K), .DATA_W(DW), .ACC_W(ACC_A)) u_dut (
    .clk(clk), .reset(reset), .CONV_start(start), .CONV_wData(wData),
    .CONV_wValid(wValid), .CONV_iData(iData), .CONV_iValid(iValid),
    .CONV_iReady(iReady_a), .CONV_oData(oData_a), .CONV_oValid(oValid_a),
    .CONV_oReady(oReady), .CONV_finish(finish_a)
  );

  conv_stream #(.IMG_W(W), .IMG_H(H), .K(K), .DATA_W(DW), .ACC_W(ACC_B)) u_dut16 (
    .clk(clk), .reset(reset), .CONV_start(start), .CONV_wData(wData),
    .CONV_wValid(wValid), .CONV_iData(iData), .CONV_iValid(iValid),
    .CONV_iReady(iReady_b), .CONV_oData(oData_b), .CONV_oValid(oValid_b),
    .CONV_oReady(oReady), .CONV_finish(finish_b)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference state: coefficients as the design should hold them, frame pixels.
  int mcoef [NC];
  int m_widx;
  int pix   [NPIX];

  longint got_a[$], got_b[$], exp_a[$], exp_b[$];
  int fin_a, fin_b, timeout, stall_cycles, stall_bad, first_out_cyc, win_acc_cyc;

  // Valid-window convolution straight from the definition.
  function automatic longint ref_conv(input int r, input int c, input int accw);
    longint s, hi, lo;
    s = 0;
    for (int i = 0; i < K; i++)
      for (int j = 0; j < K; j++)
        s += longint'(mcoef[i*K+j]) * longint'(pix[(r+i)*W + c + j]);
    hi = (longint'(1) <<< (accw - 1)) - 1;
    lo = -hi - 1;
    if (s > hi) s = hi;
    if (s < lo) s = lo;
`ifdef CONV_RELU_EN
    if (s < 0) s = 0;
`endif
    return s;
  endfunction

  task automatic build_exp();
    exp_a.delete();
    exp_b.delete();
    for (int r = 0; r <= H - K; r++)
      for (int c = 0; c <= W - K; c++) begin
        exp_a.push_back(ref_conv(r, c, ACC_A));
        exp_b.push_back(ref_conv(r, c, ACC_B));
      end
  endtask

  task automatic load_coef(input int v);
    @(negedge clk);
    wValid = 1'b1;
    wData  = DW'(v);
    mcoef[m_widx] = v;
    m_widx = (m_widx + 1) % NC;
    @(negedge clk);
    wValid = 1'b0;
  endtask

  task automatic load_identity();
    for (int i = 0; i < NC; i++) load_coef((i == NC / 2) ? 1 : 0);
  endtask

  task automatic load_const(input int v);
    for (int i = 0; i < NC; i++) load_coef(v);
  endtask

  task automatic clear_model();
    for (int i = 0; i < NC; i++) mcoef[i] = 0;
    m_widx = 0;
  endtask

  // mode 0: full throughput; 1: random valid/ready; 2: oReady low 5 cycles after 3rd result.
  // noise: random coefficient strobes on the start cycle and during the frame.
  task automatic run_frame(input int mode, input bit noise);
    int idx, cyc, post, hold_cnt;
    bit prev_stall, stl, fin_seen;
    logic signed [ACC_A-1:0] held;
    idx = 0; cyc = 0; post = 0; hold_cnt = 0;
    prev_stall = 0; fin_seen = 0; held = '0;
    got_a.delete(); got_b.delete();
    fin_a = 0; fin_b = 0; timeout = 0; stall_cycles = 0; stall_bad = 0;
    first_out_cyc = -1; win_acc_cyc = -1;
    @(negedge clk);
    start  = 1'b1;
    wValid = noise;
    wData  = DW'($urandom);
    m_widx = 0;
    @(negedge clk);
    start = 1'b0;
    while (post < 6) begin
      wValid = noise && !fin_seen && ($urandom_range(0, 1) == 1);
      wData  = DW'($urandom);
      if (idx < NPIX) begin
        iValid = (mode == 1) ? ($urandom_range(0, 3) != 0) : 1'b1;
        iData  = DW'(pix[idx]);
      end else begin
        iValid = 1'b0;
        iData  = '0;
      end
      case (mode)
        1:       oReady = ($urandom_range(0, 2) != 0);
        2:       oReady = (hold_cnt == 0);
        default: oReady = 1'b1;
      endcase
      #1;
      stl = oValid_a && !oReady;
      if (stl) begin
        stall_cycles++;
        if (iReady_a !== 1'b0 || iReady_b !== 1'b0) stall_bad++;
        if (prev_stall && oData_a !== held) stall_bad++;
        held = oData_a;
      end
      prev_stall = stl;
      if (iValid && iReady_a) begin
        if (idx == (K - 1) * W + K - 1) win_acc_cyc = cyc;
        idx++;
      end
      if (oValid_a && first_out_cyc < 0) first_out_cyc = cyc;
      if (mode == 2 && hold_cnt > 0) hold_cnt--;
      if (oValid_a && oReady) begin
        got_a.push_back(longint'(oData_a));
        if (mode == 2 && got_a.size() == 3) hold_cnt = 5;
      end
      if (oValid_b && oReady) got_b.push_back(longint'(oData_b));
      if (finish_a) begin fin_a++; fin_seen = 1; end
      if (finish_b) fin_b++;
      if (fin_seen) post++;
      cyc++;
      if (cyc > 3000) begin timeout = 1; break; end
      @(negedge clk);
    end
    wValid = 1'b0; iValid = 1'b0; iData = '0; oReady = 1'b0;
  endtask

  task automatic test_reset();
    int bad;
    load_coef(5);
    load_coef(-3);
    @(negedge clk);
    reset = 1'b0;
    clear_model();
    #1;
    n_tests++; if (iReady_a !== 1'b0 || iReady_b !== 1'b0) begin $display("FAIL rst_iready got %b/%b want 0", iReady_a, iReady_b); n_fail++; end
    n_tests++; if (oValid_a !== 1'b0 || oValid_b !== 1'b0) begin $display("FAIL rst_ovalid got %b/%b want 0", oValid_a, oValid_b); n_fail++; end
    n_tests++; if (oData_a !== '0 || oData_b !== '0) begin $display("FAIL rst_odata got %0d/%0d want 0", oData_a, oData_b); n_fail++; end
    n_tests++; if (finish_a !== 1'b0 || finish_b !== 1'b0) begin $display("FAIL rst_finish got %b/%b want 0", finish_a, finish_b); n_fail++; end
    @(negedge clk);
    reset  = 1'b1;
    iValid = 1'b1;
    oReady = 1'b1;
    bad = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      #1;
      if (iReady_a !== 1'b0 || iReady_b !== 1'b0) bad++;
    end
    n_tests++; if (bad != 0) begin $display("FAIL rst_iready_idle got %0d high cycles want 0", bad); n_fail++; end
    iValid = 1'b0;
    oReady = 1'b0;
  endtask

  task automatic test_identity();
    for (int i = 0; i < NPIX; i++) pix[i] = i + 1;
    load_identity();
    run_frame(0, 1'b0);
    build_exp();
    n_tests++; if (timeout != 0 || got_a.size() != NOUT || got_b.size() != NOUT) begin $display("FAIL ident_count got %0d/%0d want %0d timeout=%0d", got_a.size(), got_b.size(), NOUT, timeout); n_fail++; end
    for (int i = 0; i < NOUT && i < got_a.size() && i < got_b.size(); i++) begin
      n_tests++; if (got_a[i] !== exp_a[i] || got_b[i] !== exp_b[i]) begin $display("FAIL ident_res[%0d] got %0d/%0d want %0d/%0d", i, got_a[i], got_b[i], exp_a[i], exp_b[i]); n_fail++; end
    end
    n_tests++; if (fin_a != 1 || fin_b != 1) begin $display("FAIL ident_finish got %0d/%0d pulses want 1", fin_a, fin_b); n_fail++; end
    n_tests++; if (win_acc_cyc < 0 || first_out_cyc - win_acc_cyc != 2) begin $display("FAIL ident_latency got %0d want 2", first_out_cyc - win_acc_cyc); n_fail++; end
  endtask

  task automatic test_ones_neg();
    for (int i = 0; i < NPIX; i++) pix[i] = -128;
    load_const(1);
    run_frame(1, 1'b1);
    build_exp();
    n_tests++; if (timeout != 0 || got_a.size() != NOUT || got_b.size() != NOUT) begin $display("FAIL ones_count got %0d/%0d want %0d timeout=%0d", got_a.size(), got_b.size(), NOUT, timeout); n_fail++; end
    for (int i = 0; i < NOUT && i < got_a.size() && i < got_b.size(); i++) begin
      n_tests++; if (got_a[i] !== exp_a[i] || got_b[i] !== exp_b[i]) begin $display("FAIL ones_res[%0d] got %0d/%0d want %0d/%0d", i, got_a[i], got_b[i], exp_a[i], exp_b[i]); n_fail++; end
    end
    n_tests++; if (fin_a != 1 || fin_b != 1) begin $display("FAIL ones_finish got %0d/%0d pulses want 1", fin_a, fin_b); n_fail++; end
  endtask

  task automatic test_saturation();
    for (int i = 0; i < NPIX; i++) pix[i] = -128;
    load_const(-128);
    run_frame(1, 1'b0);
    build_exp();
    n_tests++; if (timeout != 0 || got_a.size() != NOUT || got_b.size() != NOUT) begin $display("FAIL sat_count got %0d/%0d want %0d timeout=%0d", got_a.size(), got_b.size(), NOUT, timeout); n_fail++; end
    for (int i = 0; i < NOUT && i < got_a.size() && i < got_b.size(); i++) begin
      n_tests++; if (got_a[i] !== exp_a[i] || got_b[i] !== exp_b[i]) begin $display("FAIL sat_res[%0d] got %0d/%0d want %0d/%0d", i, got_a[i], got_b[i], exp_a[i], exp_b[i]); n_fail++; end
    end
  endtask

  task automatic test_stall();
    for (int i = 0; i < NPIX; i++) pix[i] = i + 1;
    load_identity();
    run_frame(2, 1'b0);
    build_exp();
    n_tests++; if (timeout != 0 || got_a.size() != NOUT || got_b.size() != NOUT) begin $display("FAIL stall_count got %0d/%0d want %0d timeout=%0d", got_a.size(), got_b.size(), NOUT, timeout); n_fail++; end
    for (int i = 0; i < NOUT && i < got_a.size() && i < got_b.size(); i++) begin
      n_tests++; if (got_a[i] !== exp_a[i] || got_b[i] !== exp_b[i]) begin $display("FAIL stall_res[%0d] got %0d/%0d want %0d/%0d", i, got_a[i], got_b[i], exp_a[i], exp_b[i]); n_fail++; end
    end
    n_tests++; if (stall_cycles != 5) begin $display("FAIL stall_cycles got %0d want 5", stall_cycles); n_fail++; end
    n_tests++; if (stall_bad != 0) begin $display("FAIL stall_hold got %0d violations want 0", stall_bad); n_fail++; end
    n_tests++; if (fin_a != 1 || fin_b != 1) begin $display("FAIL stall_finish got %0d/%0d pulses want 1", fin_a, fin_b); n_fail++; end
  endtask

  task automatic test_abort();
    int cnt, guard, fins;
    for (int i = 0; i < NPIX; i++) pix[i] = i + 1;
    load_identity();
    @(negedge clk);
    start = 1'b1;
    m_widx = 0;
    @(negedge clk);
    start  = 1'b0;
    oReady = 1'b1;
    cnt = 0;
    guard = 0;
    while (cnt < 20 && guard < 200) begin
      iValid = 1'b1;
      iData  = DW'(pix[cnt]);
      #1;
      if (iReady_a) cnt++;
      @(negedge clk);
      guard++;
    end
    iValid = 1'b0;
    n_tests++; if (cnt != 20) begin $display("FAIL abort_feed got %0d pixels want 20", cnt); n_fail++; end
    reset = 1'b0;
    clear_model();
    repeat (2) @(negedge clk);
    reset = 1'b1;
    fins = 0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      #1;
      if (finish_a || finish_b || oValid_a || oValid_b) fins++;
    end
    n_tests++; if (fins != 0) begin $display("FAIL abort_no_finish got %0d active cycles want 0", fins); n_fail++; end
    oReady = 1'b0;
    load_identity();
    run_frame(1, 1'b0);
    build_exp();
    n_tests++; if (timeout != 0 || got_a.size() != NOUT || got_b.size() != NOUT) begin $display("FAIL abort_count got %0d/%0d want %0d timeout=%0d", got_a.size(), got_b.size(), NOUT, timeout); n_fail++; end
    for (int i = 0; i < NOUT && i < got_a.size() && i < got_b.size(); i++) begin
      n_tests++; if (got_a[i] !== exp_a[i] || got_b[i] !== exp_b[i]) begin $display("FAIL abort_res[%0d] got %0d/%0d want %0d/%0d", i, got_a[i], got_b[i], exp_a[i], exp_b[i]); n_fail++; end
    end
    n_tests++; if (fin_a != 1 || fin_b != 1) begin $display("FAIL abort_finish got %0d/%0d pulses want 1", fin_a, fin_b); n_fail++; end
  endtask

  // Random kernels and pixels across back-to-back frames; extra writes wrap
  // the load index, and a frame start must rewind it for the next load.
  task automatic test_back_to_back();
    for (int f = 0; f < 3; f++) begin
      if (f == 0) begin
        for (int i = 0; i < NC + 4; i++) load_coef(int'($urandom_range(0, 255)) - 128);
      end else if (f == 2) begin
        for (int i = 0; i < 4; i++) load_coef(int'($urandom_range(0, 255)) - 128);
      end
      for (int i = 0; i < NPIX; i++) pix[i] = int'($urandom_range(0, 255)) - 128;
      run_frame(1, 1'b1);
      build_exp();
      n_tests++; if (timeout != 0 || got_a.size() != NOUT || got_b.size() != NOUT) begin $display("FAIL b2b%0d_count got %0d/%0d want %0d timeout=%0d", f, got_a.size(), got_b.size(), NOUT, timeout); n_fail++; end
      for (int i = 0; i < NOUT && i < got_a.size() && i < got_b.size(); i++) begin
        n_tests++; if (got_a[i] !== exp_a[i] || got_b[i] !== exp_b[i]) begin $display("FAIL b2b%0d_res[%0d] got %0d/%0d want %0d/%0d", f, i, got_a[i], got_b[i], exp_a[i], exp_b[i]); n_fail++; end
      end
      n_tests++; if (fin_a != 1 || fin_b != 1) begin $display("FAIL b2b%0d_finish got %0d/%0d pulses want 1", f, fin_a, fin_b); n_fail++; end
    end
  endtask

  initial begin
    start = 1'b0; wValid = 1'b0; wData = '0;
    iValid = 1'b0; iData = '0; oReady = 1'b0;
    reset = 1'b0;
    clear_model();
    repeat (3) @(negedge clk);
    reset = 1'b1;
    test_reset();
    test_identity();
    test_ones_neg();
    test_saturation();
    test_stall();
    test_abort();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/conv_stream.md
CONV_STREAM -- requirements
Module: conv_stream

Interface
REQ-001 Parameter IMG_W, default 6, input image width in pixels (>= K).
REQ-002 Parameter IMG_H, default 6, input image height in pixels (>= K).
REQ-003 Parameter K, default 3, square kernel size (odd, 1..7).
REQ-004 Parameter DATA_W, default 8, signed pixel and coefficient width.
REQ-005 Parameter ACC_W, default 20, signed result width.
REQ-006 Port clk, input, 1, sole clock; all state on rising edge.
REQ-007 Port reset, input, 1, asynchronous active-low reset.
REQ-008 Port CONV_start, input, 1, one-cycle pulse opening a frame.
REQ-009 Port CONV_wData, input, DATA_W, signed kernel coefficient.
REQ-010 Port CONV_wValid, input, 1, coefficient write strobe.
REQ-011 Port CONV_iData, input, DATA_W, signed pixel, raster order.
REQ-012 Port CONV_iValid, input, 1, pixel valid.
REQ-013 Port CONV_iReady, output, 1, pixel accepted when iValid && iReady.
REQ-014 Port CONV_oData, output, ACC_W, signed convolution result.
REQ-015 Port CONV_oValid, output, 1, result valid; held with data stable until oReady.
REQ-016 Port CONV_oReady, input, 1, downstream accept.
REQ-017 Port CONV_finish, output, 1, one-cycle pulse after last result accepted.

Function
REQ-018 FSM states IDLE, RUN, DRAIN, DONE; IDLE->RUN on CONV_start; RUN->DRAIN after IMG_W*IMG_H pixels accepted; DRAIN->DONE when pipeline empty and last result accepted; DONE->IDLE next cycle with CONV_finish high for that one cycle.
REQ-019 In IDLE only, each CONV_wValid writes the next of K*K coefficients, row-major, via index wrapping to 0 after K*K-1; CONV_start in IDLE also resets the index to 0.
REQ-020 CONV_start and CONV_wValid in the same IDLE cycle: start taken, coefficient write dropped.
REQ-021 CONV_start outside IDLE and CONV_wValid outside IDLE are ignored.
REQ-022 CONV_iReady high only in RUN and not stalled; stall = CONV_oValid && !CONV_oReady; stall freezes the whole pipeline.
REQ-023 Column counter wraps IMG_W-1->0 and increments row; (IMG_H-K+1)*(IMG_W-K+1) results per frame, valid-window only (no padding), stride 1, raster order.
REQ-024 Result for window whose bottom-right pixel is accepted in cycle t appears on CONV_oValid in cycle t+2 absent stall (stage 1 multiply, stage 2 adder tree and output register).
REQ-025 Products full precision (2*DATA_W), sum full precision, then saturated to signed ACC_W range.
REQ-026 Line buffers hold K-1 rows of IMG_W pixels; window registers K x K.

Reset
REQ-027 reset low: state IDLE, all counters, line buffers, window, coefficients and pipeline cleared to 0; CONV_iReady, CONV_oValid, CONV_finish 0; CONV_oData 0.
REQ-028 reset mid-frame discards the frame; no CONV_finish produced.

Configuration
REQ-029 Macro CONV_RELU_EN defined: saturated negative results output as 0; undefined: signed result passed unchanged. Latency identical in both builds.

Structure
REQ-030 Package conv_pkg holds the FSM state enum, the ACC_W derivation constant (2*DATA_W+clog2(K*K)) and the saturation function.
REQ-031 Sub-module conv_line_buf (one row-delay buffer, depth IMG_W, stall-aware) instantiated K-1 times.

Verification
REQ-032 Reset asserted mid-idle -> all outputs 0, CONV_iReady 0 after release until CONV_start.
REQ-033 Defaults, identity kernel (centre 1, others 0), pixels 1..36 -> 16 results 8,9,10,11,14..17,20..23,26..29 in order, then one CONV_finish pulse.
REQ-034 All-ones kernel, all pixels -128 -> 16 results of -1152; with CONV_RELU_EN -> 16 results of 0.
REQ-035 Identity-kernel frame with CONV_oReady low 5 cycles after 3rd result -> CONV_iReady low during stall, oData held, sequence identical to REQ-033.
REQ-036 ACC_W=16, all coefficients -128, all pixels -128 -> each result 32767 (147456 saturated).
REQ-037 reset pulsed after 20 pixels accepted, then reload identity kernel and full frame -> no finish for aborted frame; second frame matches REQ-033.
